bsk_mgr_cut_scheduler: RTL

- Sequences the BSK_CUT_NB bootstrapping-key cuts through SLOT_NB physical cut buffers inside the bsk_manager.
- Allocates a free buffer to the key loader for the next cut in order, and tracks load completion.
- Presents ready buffers to READER_NB consumers (PBS lanes) in cut order.
- Frees a buffer once every reader has released it. Ring order over cuts 0..BSK_CUT_NB-1, wrapping for the next key pass.

---
 rtl/bsk_mgr_cut_scheduler_if.sv | 37 +++
 rtl/bsk_mgr_cut_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bsk_mgr_cut_scheduler_if.sv
// Handshake bundle between the cut scheduler and its key loader / PBS readers.
// master: scheduler side (drives offers, receives accepts/completions/releases).
// slave : loader + readers side.
//   ld_vld/ld_rdy/ld_slot/ld_cut   : buffer allocation offer to the loader
//   ld_done/ld_done_slot           : load completion for one buffer
//   rd_vld/rd_rdy/rd_slot/rd_cut   : per-reader offer of the next ready cut (flattened)
//   rd_rel                         : per-reader release of its oldest accepted buffer
interface bsk_mgr_cut_scheduler_if #(
    parameter int unsigned BSK_CUT_NB = 2,
    parameter int unsigned SLOT_NB    = 2,
    parameter int unsigned READER_NB  = 2
);
    localparam int unsigned SLOT_W = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1;
    localparam int unsigned CUT_W  = (BSK_CUT_NB > 1) ? $clog2(BSK_CUT_NB) : 1;

    logic                          ld_vld;
    logic                          ld_rdy;
    logic [SLOT_W-1:0]             ld_slot;
    logic [CUT_W-1:0]              ld_cut;
    logic                          ld_done;
    logic [SLOT_W-1:0]             ld_done_slot;
    logic [READER_NB-1:0]          rd_vld;
    logic [READER_NB-1:0]          rd_rdy;
    logic [READER_NB*SLOT_W-1:0]   rd_slot;
    logic [READER_NB*CUT_W-1:0]    rd_cut;
    logic [READER_NB-1:0]          rd_rel;

    modport master (
        output ld_vld, ld_slot, ld_cut, rd_vld, rd_slot, rd_cut,
        input  ld_rdy, ld_done, ld_done_slot, rd_rdy, rd_rel
    );

    modport slave (
        input  ld_vld, ld_slot, ld_cut, rd_vld, rd_slot, rd_cut,
        output ld_rdy, ld_done, ld_done_slot, rd_rdy, rd_rel
    );
endinterface

// File: rtl/bsk_mgr_cut_scheduler.sv
// Sequences BSK_CUT_NB key cuts through SLOT_NB cut buffers. Buffers are handed to the
// loader in ring order, become READY on ld_done, are offered to every reader in ring
// order and return to FREE once all readers have released them.
// Ports:
//   clk, a_rst_n : clock, asynchronous active-low reset
//   enable       : allow new load allocations
//   flush        : return to initial state (refused while any buffer is loading)
//   bus          : loader / reader handshakes (master side)
//   ready_cnt    : registered number of READY buffers (lags the state by one cycle)
//   err          : one-cycle pulse, registered, after a protocol violation
module bsk_mgr_cut_scheduler #(
    parameter int unsigned BSK_CUT_NB = 2,
    parameter int unsigned SLOT_NB    = 2,
    parameter int unsigned READER_NB  = 2
) (
    input  logic                           clk,
    input  logic                           a_rst_n,
    input  logic                           enable,
    input  logic                           flush,
    bsk_mgr_cut_scheduler_if.master        bus,
    output logic [$clog2(SLOT_NB+1)-1:0]   ready_cnt,
    output logic                           err
);
    localparam int unsigned SLOT_W = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1;
    localparam int unsigned CUT_W  = (BSK_CUT_NB > 1) ? $clog2(BSK_CUT_NB) : 1;
    localparam int unsigned CNT_W  = $clog2(SLOT_NB + 1);

    typedef enum logic [1:0] {StFree, StLoading, StReady} slot_st_e;

    slot_st_e             state_q   [SLOT_NB];
    slot_st_e             state_d   [SLOT_NB];
    logic [CUT_W-1:0]     cut_id_q  [SLOT_NB];
    logic [CUT_W-1:0]     cut_id_d  [SLOT_NB];
    logic [READER_NB-1:0] taken_q   [SLOT_NB];
    logic [READER_NB-1:0] taken_d   [SLOT_NB];
    logic [READER_NB-1:0] rel_q     [SLOT_NB];
    logic [READER_NB-1:0] rel_d     [SLOT_NB];

    logic [SLOT_W-1:0]    rd_ptr_q  [READER_NB];
    logic [SLOT_W-1:0]    rd_ptr_d  [READER_NB];
    logic [SLOT_W-1:0]    rel_ptr_q [READER_NB];
    logic [SLOT_W-1:0]    rel_ptr_d [READER_NB];
    logic [CNT_W-1:0]     out_cnt_q [READER_NB];
    logic [CNT_W-1:0]     out_cnt_d [READER_NB];

    logic [SLOT_W-1:0]    ld_ptr_q, ld_ptr_d;
    logic [CUT_W-1:0]     ld_cut_q, ld_cut_d;
    logic [CNT_W-1:0]     ready_cnt_q, ready_cnt_d;
    logic                 err_q, err_d;

    logic                 ld_vld, ld_hs;
    logic [READER_NB-1:0] rd_vld, rd_hs, rel_ok;
    logic                 any_loading, done_ok, flush_ok;
    logic [CNT_W-1:0]     ready_now;

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] p);
        return (p == SLOT_W'(SLOT_NB - 1)) ? '0 : p + SLOT_W'(1);
    endfunction

    function automatic logic [CUT_W-1:0] cut_inc(input logic [CUT_W-1:0] p);
        return (p == CUT_W'(BSK_CUT_NB - 1)) ? '0 : p + CUT_W'(1);
    endfunction

    // Status decode and handshake qualification, all from registered state.
    always_comb begin
        any_loading = 1'b0;
        done_ok     = 1'b0;
        ready_now   = '0;
        for (int s = 0; s < SLOT_NB; s++) begin
            if (state_q[s] == StLoading) begin
                any_loading = 1'b1;
                if (bus.ld_done_slot == SLOT_W'(s)) done_ok = bus.ld_done;
            end
            if (state_q[s] == StReady) ready_now = ready_now + CNT_W'(1);
        end
        flush_ok = flush && !any_loading;
        ld_vld   = enable && !flush && (state_q[ld_ptr_q] == StFree);
        ld_hs    = ld_vld && bus.ld_rdy;
        for (int r = 0; r < READER_NB; r++) begin
            // Strict in-order delivery: only the slot at rd_ptr is ever offered.
            rd_vld[r] = (state_q[rd_ptr_q[r]] == StReady) && !taken_q[rd_ptr_q[r]][r];
            rd_hs[r]  = rd_vld[r] && bus.rd_rdy[r];
            rel_ok[r] = bus.rd_rel[r] && (out_cnt_q[r] != '0);
        end
    end

    always_comb begin
        bus.rd_slot = '0;
        bus.rd_cut  = '0;
        for (int r = 0; r < READER_NB; r++) begin
            bus.rd_slot[r*SLOT_W +: SLOT_W] = rd_ptr_q[r];
            bus.rd_cut[r*CUT_W +: CUT_W]    = cut_id_q[rd_ptr_q[r]];
        end
    end

    assign bus.ld_vld  = ld_vld;
    assign bus.ld_slot = ld_ptr_q;
    assign bus.ld_cut  = ld_cut_q;
    assign bus.rd_vld  = rd_vld;
    assign ready_cnt   = ready_cnt_q;
    assign err         = err_q;

    always_comb begin
        state_d     = state_q;
        cut_id_d    = cut_id_q;
        taken_d     = taken_q;
        rel_d       = rel_q;
        rd_ptr_d    = rd_ptr_q;
        rel_ptr_d   = rel_ptr_q;
        out_cnt_d   = out_cnt_q;
        ld_ptr_d    = ld_ptr_q;
        ld_cut_d    = ld_cut_q;
        ready_cnt_d = ready_now;
        err_d       = (bus.ld_done && !done_ok) || (|(bus.rd_rel & ~rel_ok)) ||
                      (flush && any_loading);

        if (ld_hs) begin
            ld_ptr_d = slot_inc(ld_ptr_q);
            ld_cut_d = cut_inc(ld_cut_q);
        end

        for (int r = 0; r < READER_NB; r++) begin
            if (rd_hs[r])  rd_ptr_d[r]  = slot_inc(rd_ptr_q[r]);
            if (rel_ok[r]) rel_ptr_d[r] = slot_inc(rel_ptr_q[r]);
            out_cnt_d[r] = out_cnt_q[r] + CNT_W'(rd_hs[r]) - CNT_W'(rel_ok[r]);
        end

        // Load, completion and release always hit slots in different states, so the
        // per-slot updates below never collide.
        for (int s = 0; s < SLOT_NB; s++) begin
            if (ld_hs && (ld_ptr_q == SLOT_W'(s))) begin
                state_d[s]  = StLoading;
                cut_id_d[s] = ld_cut_q;
            end
            if (done_ok && (bus.ld_done_slot == SLOT_W'(s))) begin
                state_d[s] = StReady;
                taken_d[s] = '0;
                rel_d[s]   = '0;
            end
            for (int r = 0; r < READER_NB; r++) begin
                if (rd_hs[r] && (rd_ptr_q[r] == SLOT_W'(s)))   taken_d[s][r] = 1'b1;
                if (rel_ok[r] && (rel_ptr_q[r] == SLOT_W'(s))) rel_d[s][r]   = 1'b1;
            end
            if ((state_q[s] == StReady) && (rel_d[s] == '1)) state_d[s] = StFree;
        end

        // An accepted flush overrides every same-cycle event.
        if (flush_ok) begin
            for (int s = 0; s < SLOT_NB; s++) begin
                state_d[s]  = StFree;
                cut_id_d[s] = '0;
                taken_d[s]  = '0;
                rel_d[s]    = '0;
            end
            for (int r = 0; r < READER_NB; r++) begin
                rd_ptr_d[r]  = '0;
                rel_ptr_d[r] = '0;
                out_cnt_d[r] = '0;
            end
            ld_ptr_d    = '0;
            ld_cut_d    = '0;
            ready_cnt_d = '0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int s = 0; s < SLOT_NB; s++) begin
                state_q[s]  <= StFree;
                cut_id_q[s] <= '0;
                taken_q[s]  <= '0;
                rel_q[s]    <= '0;
            end
            for (int r = 0; r < READER_NB; r++) begin
                rd_ptr_q[r]  <= '0;
                rel_ptr_q[r] <= '0;
                out_cnt_q[r] <= '0;
            end
            ld_ptr_q    <= '0;
            ld_cut_q    <= '0;
            ready_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cut_id_q    <= cut_id_d;
            taken_q     <= taken_d;
            rel_q       <= rel_d;
            rd_ptr_q    <= rd_ptr_d;
            rel_ptr_q   <= rel_ptr_d;
            out_cnt_q   <= out_cnt_d;
            ld_ptr_q    <= ld_ptr_d;
            ld_cut_q    <= ld_cut_d;
            ready_cnt_q <= ready_cnt_d;
            err_q       <= err_d;
        end
    end
endmodule
